evaluate_mob_sum: RTL and testbench

Consumer end of the per-square mobility score interface. The block collects the signed `eval_mg`/`eval_eg` terms from every `evaluate_mob_square` instance on one board and reduces them, through a pipelined 4-input adder tree, to one saturated midgame/endgame mobility score per board. It tracks `board_valid` through the square instances' fixed latency and emits a single-cycle `out_valid` aligned with the totals. It feeds the top-level evaluation summer.

---
 rtl/evaluate_mob_sum_pkg.sv | 41 ++++
 rtl/evaluate_mob_sum_add4.sv | 29 ++
 rtl/evaluate_mob_sum.sv | 162 ++++++++++++++++
 tb/tb_evaluate_mob_sum.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/evaluate_mob_sum_pkg.sv
// Shared mobility-summer constants, piece codes and tree-shape helpers.
// Used by evaluate_mob_sum (optional taper stage under MOBILITY_TAPER_EN).
package evaluate_mob_sum_pkg;

    localparam int unsigned MOB_PHASE_MAX   = 64;
    localparam int unsigned MOB_PHASE_SHIFT = 6;
    localparam int unsigned MOB_SQUARES     = 64;

    typedef enum logic [2:0] {
        MOB_W_KNIGHT, MOB_W_BISHOP, MOB_W_ROOK, MOB_W_QUEEN,
        MOB_B_KNIGHT, MOB_B_BISHOP, MOB_B_ROOK, MOB_B_QUEEN
    } mob_piece_e;

    localparam int unsigned MOB_PIECE_CODES   = 1 << $bits(mob_piece_e);
    localparam int unsigned MOB_TERMS_DEFAULT = MOB_SQUARES * MOB_PIECE_CODES;

    // Number of 4:1 reduction levels needed to fold n terms into one.
    function automatic int unsigned mob_stages(input int unsigned n);
        int unsigned s    = 0;
        int unsigned span = 1;
        while (span < n) begin
            span = span * 4;
            s++;
        end
        return s;
    endfunction

    function automatic int unsigned mob_lvl_cnt(input int unsigned n, input int unsigned lvl);
        int unsigned c = n;
        for (int unsigned i = 0; i < lvl; i++) c = (c + 3) / 4;
        return c;
    endfunction

    // Index of the first node of a level when all levels are laid out back to back.
    function automatic int unsigned mob_lvl_off(input int unsigned n, input int unsigned lvl);
        int unsigned off = 0;
        for (int unsigned i = 0; i < lvl; i++) off += mob_lvl_cnt(n, i);
        return off;
    endfunction

endpackage

// File: rtl/evaluate_mob_sum_add4.sv
// eval_add4: registered 4-input signed adder carrying a valid bit.
// One instance per group at every level of the mobility adder tree.
module eval_add4
    import evaluate_mob_sum_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    input  logic signed [W-1:0] i_a,
    input  logic signed [W-1:0] i_b,
    input  logic signed [W-1:0] i_c,
    input  logic signed [W-1:0] i_d,
    output logic signed [W-1:0] o_sum,
    output logic                o_valid
);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_sum   <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= i_valid;
            if (i_valid) o_sum <= i_a + i_b + i_c + i_d;
        end
    end

endmodule

// File: rtl/evaluate_mob_sum.sv
// Reduces per-square mobility terms to one saturated mg/eg score per board.
// Defining MOBILITY_TAPER_EN adds a phase-tapered output one cycle later.
module evaluate_mob_sum
    import evaluate_mob_sum_pkg::*;
#(
    parameter int unsigned EVAL_WIDTH  = 16,
    parameter int unsigned TERMS       = MOB_TERMS_DEFAULT,
    parameter int unsigned SRC_LATENCY = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          board_valid,
    input  logic [TERMS*EVAL_WIDTH-1:0]   mg_terms,
    input  logic [TERMS*EVAL_WIDTH-1:0]   eg_terms,
`ifdef MOBILITY_TAPER_EN
    input  logic [6:0]                    phase,
    output logic signed [EVAL_WIDTH-1:0]  eval_taper,
`endif
    output logic signed [EVAL_WIDTH-1:0]  eval_mg,
    output logic signed [EVAL_WIDTH-1:0]  eval_eg,
    output logic                          out_valid
);

    localparam int unsigned S      = mob_stages(TERMS);
    localparam int unsigned IW     = EVAL_WIDTH + 2 * S;
    localparam int unsigned NODES  = mob_lvl_off(TERMS, S + 1);
    localparam int unsigned GROUPS = NODES - TERMS;
    localparam logic signed [EVAL_WIDTH-1:0] SAT_MAX = {1'b0, {(EVAL_WIDTH-1){1'b1}}};
    localparam logic signed [EVAL_WIDTH-1:0] SAT_MIN = {1'b1, {(EVAL_WIDTH-1){1'b0}}};

    logic [SRC_LATENCY-1:0]  r_vsh;
    logic [S:0]              w_lv;
    logic signed [IW-1:0]    w_mg_node [NODES];
    logic signed [IW-1:0]    w_eg_node [NODES];
    logic [GROUPS-1:0]       w_mg_gv;
    logic [GROUPS-1:0]       w_eg_gv;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vsh <= '0;
        end else begin
            r_vsh[0] <= board_valid;
            for (int unsigned i = 1; i < SRC_LATENCY; i++) r_vsh[i] <= r_vsh[i-1];
        end
    end

    assign w_lv[0] = r_vsh[SRC_LATENCY-1];

    for (genvar k = 0; k < TERMS; k++) begin : g_in
        assign w_mg_node[k] = {{(IW-EVAL_WIDTH){mg_terms[k*EVAL_WIDTH+EVAL_WIDTH-1]}},
                               mg_terms[k*EVAL_WIDTH +: EVAL_WIDTH]};
        assign w_eg_node[k] = {{(IW-EVAL_WIDTH){eg_terms[k*EVAL_WIDTH+EVAL_WIDTH-1]}},
                               eg_terms[k*EVAL_WIDTH +: EVAL_WIDTH]};
    end

    // Levels are packed into one node array; level s feeds level s+1 in groups of 4.
    for (genvar s = 0; s < S; s++) begin : g_lvl
        localparam int unsigned N_IN  = mob_lvl_cnt(TERMS, s);
        localparam int unsigned N_OUT = mob_lvl_cnt(TERMS, s + 1);
        localparam int unsigned I_OFF = mob_lvl_off(TERMS, s);
        localparam int unsigned O_OFF = mob_lvl_off(TERMS, s + 1);

        for (genvar g = 0; g < N_OUT; g++) begin : g_grp
            logic signed [IW-1:0] w_mg_in [4];
            logic signed [IW-1:0] w_eg_in [4];

            for (genvar j = 0; j < 4; j++) begin : g_pad
                if (4 * g + j < N_IN) begin : g_tap
                    assign w_mg_in[j] = w_mg_node[I_OFF + 4*g + j];
                    assign w_eg_in[j] = w_eg_node[I_OFF + 4*g + j];
                end else begin : g_zero
                    assign w_mg_in[j] = '0;
                    assign w_eg_in[j] = '0;
                end
            end

            eval_add4 #(.W(IW)) u_mg (
                .i_clk(clk), .i_rst_n(reset), .i_valid(w_lv[s]),
                .i_a(w_mg_in[0]), .i_b(w_mg_in[1]), .i_c(w_mg_in[2]), .i_d(w_mg_in[3]),
                .o_sum(w_mg_node[O_OFF + g]), .o_valid(w_mg_gv[O_OFF - TERMS + g])
            );
            eval_add4 #(.W(IW)) u_eg (
                .i_clk(clk), .i_rst_n(reset), .i_valid(w_lv[s]),
                .i_a(w_eg_in[0]), .i_b(w_eg_in[1]), .i_c(w_eg_in[2]), .i_d(w_eg_in[3]),
                .o_sum(w_eg_node[O_OFF + g]), .o_valid(w_eg_gv[O_OFF - TERMS + g])
            );
        end

        assign w_lv[s+1] = (&w_mg_gv[O_OFF - TERMS +: N_OUT]) & (&w_eg_gv[O_OFF - TERMS +: N_OUT]);
    end

    function automatic logic signed [EVAL_WIDTH-1:0] f_sat(input logic signed [IW-1:0] v);
        logic [IW-EVAL_WIDTH:0] hi;
        hi = v[IW-1:EVAL_WIDTH-1];
        if ((&hi) || !(|hi)) return v[EVAL_WIDTH-1:0];
        return v[IW-1] ? SAT_MIN : SAT_MAX;
    endfunction

    logic signed [EVAL_WIDTH-1:0] w_mg_sat;
    logic signed [EVAL_WIDTH-1:0] w_eg_sat;

    assign w_mg_sat = f_sat(w_mg_node[NODES-1]);
    assign w_eg_sat = f_sat(w_eg_node[NODES-1]);

`ifdef MOBILITY_TAPER_EN
    localparam int unsigned TW = EVAL_WIDTH + 9;

    logic signed [EVAL_WIDTH-1:0] r_mg;
    logic signed [EVAL_WIDTH-1:0] r_eg;
    logic [6:0]                   r_ph;
    logic                         r_v;
    logic [6:0]                   w_ph_cl;
    logic [6:0]                   w_ph_inv;
    logic signed [TW-1:0]         w_tp;

    assign w_ph_cl  = (phase > 7'(MOB_PHASE_MAX)) ? 7'(MOB_PHASE_MAX) : phase;
    assign w_ph_inv = 7'(MOB_PHASE_MAX) - r_ph;
    assign w_tp     = TW'(r_mg) * TW'($signed({1'b0, r_ph}))
                    + TW'(r_eg) * TW'($signed({1'b0, w_ph_inv}));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mg       <= '0;
            r_eg       <= '0;
            r_ph       <= '0;
            r_v        <= 1'b0;
            eval_mg    <= '0;
            eval_eg    <= '0;
            eval_taper <= '0;
            out_valid  <= 1'b0;
        end else begin
            r_v       <= w_lv[S];
            out_valid <= r_v;
            if (w_lv[S]) begin
                r_mg <= w_mg_sat;
                r_eg <= w_eg_sat;
                r_ph <= w_ph_cl;
            end
            if (r_v) begin
                eval_mg    <= r_mg;
                eval_eg    <= r_eg;
                eval_taper <= EVAL_WIDTH'(w_tp >>> MOB_PHASE_SHIFT);
            end
        end
    end
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            eval_mg   <= '0;
            eval_eg   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= w_lv[S];
            if (w_lv[S]) begin
                eval_mg <= w_mg_sat;
                eval_eg <= w_eg_sat;
            end
        end
    end
`endif

endmodule

// File: tb/tb_evaluate_mob_sum.sv
// Bench for evaluate_mob_sum: table of board patterns plus scoreboard of expected results.
// Taper checks are active when MOBILITY_TAPER_EN is defined.
module tb_evaluate_mob_sum;

    localparam int W       = 16;
    localparam int T       = 512;
    localparam int SRC_LAT = 4;
    localparam int STAGES  = 5;
`ifdef MOBILITY_TAPER_EN
    localparam int LAT = SRC_LAT + STAGES + 1;
`else
    localparam int LAT = SRC_LAT + STAGES;
`endif
    localparam int K_PAIR = 0;
    localparam int K_UNI  = 1;
    localparam int K_RAMP = 2;

    typedef logic [T*W-1:0] vec_t;
    typedef struct {
        int kind; int a; int b; int c; int d; int ph;
        int exp_mg; int exp_eg; int exp_tp;
    } vec_rec_t;
    typedef struct {
        int mg; int eg; int tp; int unsigned at_edge;
    } sb_t;

    logic                clk;
    logic                rst_n;
    logic                board_valid;
    vec_t                mg_terms;
    vec_t                eg_terms;
    logic signed [W-1:0] eval_mg;
    logic signed [W-1:0] eval_eg;
    logic                out_valid;
`ifdef MOBILITY_TAPER_EN
    logic [6:0]          phase;
    logic signed [W-1:0] eval_taper;
`endif

    int          checks;
    int          errors;
    int unsigned edge_cnt;
    sb_t         sb[$];
    vec_t        sch_mg[int unsigned];
    vec_t        sch_eg[int unsigned];
    vec_rec_t    tbl[9];

    evaluate_mob_sum #(.EVAL_WIDTH(W), .TERMS(T), .SRC_LATENCY(SRC_LAT)) dut (
        .clk(clk),
        .reset(rst_n),
        .board_valid(board_valid),
        .mg_terms(mg_terms),
        .eg_terms(eg_terms),
`ifdef MOBILITY_TAPER_EN
        .phase(phase),
        .eval_taper(eval_taper),
`endif
        .eval_mg(eval_mg),
        .eval_eg(eval_eg),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic build(input vec_rec_t r, output vec_t mg, output vec_t eg);
        mg = '0;
        eg = '0;
        case (r.kind)
            K_PAIR: begin
                mg[0 +: W]       = 16'(r.a);
                eg[0 +: W]       = 16'(r.b);
                mg[(T-1)*W +: W] = 16'(r.c);
                eg[(T-1)*W +: W] = 16'(r.d);
            end
            K_UNI: for (int k = 0; k < T; k++) begin
                mg[k*W +: W] = 16'(r.a);
                eg[k*W +: W] = 16'(r.b);
            end
            default: for (int k = 0; k < T; k++) begin
                mg[k*W +: W] = 16'(k - 256);
                eg[k*W +: W] = 16'(k % 8);
            end
        endcase
    endtask

    // One clock: check any result, then drive this cycle's inputs (terms only on their sample cycle).
    task automatic tick(input logic bv, input vec_t mg, input vec_t eg,
                        input int emg, input int eeg, input int etp);
        int unsigned next_e;
        sb_t e;
        @(negedge clk);
        if (out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got out_valid=1 at edge %0d, expected 0", edge_cnt);
            end else begin
                e = sb.pop_front();
                chk("eval_mg", int'(eval_mg), e.mg);
                chk("eval_eg", int'(eval_eg), e.eg);
`ifdef MOBILITY_TAPER_EN
                chk("eval_taper", int'(eval_taper), e.tp);
`endif
                chk("latency_edge", int'(edge_cnt), int'(e.at_edge));
            end
        end
        rst_n       = 1'b1;
        next_e      = edge_cnt + 1;
        board_valid = bv;
        if (bv) begin
            sb.push_back('{emg, eeg, etp, next_e + LAT});
            sch_mg[next_e + SRC_LAT] = mg;
            sch_eg[next_e + SRC_LAT] = eg;
        end
        if (sch_mg.exists(next_e)) begin
            mg_terms = sch_mg[next_e];
            eg_terms = sch_eg[next_e];
            sch_mg.delete(next_e);
            sch_eg.delete(next_e);
        end else begin
            for (int i = 0; i < T*W/32; i++) begin
                mg_terms[i*32 +: 32] = $urandom();
                eg_terms[i*32 +: 32] = $urandom();
            end
        end
    endtask

    task automatic idle();
        tick(1'b0, '0, '0, 0, 0, 0);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            idle();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d boards pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_eval_mg"}, int'(eval_mg), 0);
        chk({tag, "_eval_eg"}, int'(eval_eg), 0);
`ifdef MOBILITY_TAPER_EN
        chk({tag, "_eval_taper"}, int'(eval_taper), 0);
`endif
    endtask

    initial begin
        vec_t mg;
        vec_t eg;
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        board_valid = 1'b0;
        mg_terms    = '0;
        eg_terms    = '0;
`ifdef MOBILITY_TAPER_EN
        phase       = '0;
`endif
        //            kind    a     b    c   d   ph  exp_mg  exp_eg  exp_tp
        tbl[0] = '{K_PAIR,  10,   20,  -3, -5,  32,      7,     15,     11};
        tbl[1] = '{K_UNI,  200, -200,   0,  0,   0,  32767, -32768, -32768};
        tbl[2] = '{K_UNI, -200,  200,   0,  0,  64, -32768,  32767, -32768};
        tbl[3] = '{K_UNI,    1,   -1,   0,  0,  16,    512,   -512,   -256};
        tbl[4] = '{K_UNI,   64,  -64,   0,  0, 100,  32767, -32768,  32767};
        tbl[5] = '{K_UNI,   63,  -63,   0,  0,  33,  32256, -32256,   1008};
        tbl[6] = '{K_RAMP,   0,    0,   0,  0,   1,   -256,   1792,   1760};
        tbl[7] = '{K_PAIR, 100,  -36,   0,  0,  16,    100,    -36,     -2};
        tbl[8] = '{K_PAIR, 100,  -36,   0,  0,  15,    100,    -36,     -5};

        repeat (3) @(negedge clk);
        check_zero("reset");

        for (int i = 0; i < 9; i++) begin
`ifdef MOBILITY_TAPER_EN
            phase = 7'(tbl[i].ph);
`endif
            build(tbl[i], mg, eg);
            tick(1'b1, mg, eg, tbl[i].exp_mg, tbl[i].exp_eg, tbl[i].exp_tp);
            drain(LAT + 6);
            repeat (2) idle();
        end

        // Back-to-back boards, term 5 distinct per board.
`ifdef MOBILITY_TAPER_EN
        phase = 7'd64;
`endif
        for (int i = 1; i <= 3; i++) begin
            mg = '0;
            eg = '0;
            mg[5*W +: W] = 16'(i);
            eg[5*W +: W] = 16'(-i);
            tick(1'b1, mg, eg, i, -i, i);
        end
        drain(LAT + 8);
        repeat (3) idle();

        // Reset mid-flight: the in-flight board must never surface.
        build(tbl[1], mg, eg);
        tick(1'b1, mg, eg, 32767, -32768, 0);
        repeat (3) idle();
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        sch_mg.delete();
        sch_eg.delete();
        #1;
        check_zero("midreset");
        repeat (LAT + 6) idle();
        check_zero("postreset");

        // Board issued on the same cycle reset releases.
        @(negedge clk);
        rst_n = 1'b0;
`ifdef MOBILITY_TAPER_EN
        phase = 7'd32;
`endif
        build(tbl[0], mg, eg);
        tick(1'b1, mg, eg, 7, 15, 11);
        drain(LAT + 6);
        repeat (3) idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
